imm_extend_pipe: RTL

- Parametrised immediate-extension stage for the MiniRISC decode path.
- Takes a raw immediate field of selectable width (16/22/28 bits) and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, sign-extend with word shift (branch offsets), or upper-immediate placement.
- Results are buffered in a small FIFO with valid/ready handshakes on both sides, decoupling decode from the register-read/ALU stage.

---
 rtl/imm_ext_pkg.sv | 28 ++
 rtl/imm_ext_core.sv | 56 +++++
 rtl/imm_extend_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// Shared encodings and helpers for the MiniRISC immediate-extension stage.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT  = 2'd0,
    MODE_ZEXT  = 2'd1,
    MODE_SHL2  = 2'd2,
    MODE_UPPER = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    WSEL_16   = 2'd0,
    WSEL_22   = 2'd1,
    WSEL_28   = 2'd2,
    WSEL_RSVD = 2'd3
  } imm_wsel_e;

  // Width of the raw immediate field; 0 marks the reserved selector.
  function automatic int unsigned field_width(input imm_wsel_e wsel);
    case (wsel)
      WSEL_16: return 16;
      WSEL_22: return 22;
      WSEL_28: return 28;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: field select, then SEXT/ZEXT/SHL2/UPPER.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned IN_W_MAX = 28
) (
  input  logic [IN_W_MAX-1:0] data,
  input  logic [1:0]          mode,
  input  logic [1:0]          wsel,
  output logic [OUT_W-1:0]    value,
  output logic                ovf,
  output logic                err
);

  int unsigned      w;
  logic             sign;
  logic [OUT_W-1:0] fld;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] shl;

  always_comb begin
    w    = field_width(imm_wsel_e'(wsel));
    sign = 1'b0;
    fld  = '0;
    // Bits at and above the selected width are masked off; sign is field[w-1].
    for (int unsigned i = 0; i < IN_W_MAX; i++) begin
      if (i < w) begin
        fld[i] = data[i];
        if (i == w - 1) sign = data[i];
      end
    end
    for (int unsigned i = 0; i < OUT_W; i++) begin
      sext[i] = (i < w) ? fld[i] : sign;
    end
    shl   = sext << 2;
    value = '0;
    ovf   = 1'b0;
    err   = 1'b0;
    if (w == 0) begin
      err = 1'b1;
    end else begin
      case (imm_mode_e'(mode))
        MODE_SEXT: value = sext;
        MODE_ZEXT: value = fld;
        MODE_SHL2: begin
          value = shl;
          ovf   = !((sext[OUT_W-1] == sext[OUT_W-2]) && (sext[OUT_W-2] == sext[OUT_W-3]));
        end
        MODE_UPPER: value = fld << (OUT_W - w);
        default:    value = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage with an in-order result FIFO and valid/ready on both sides.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned IN_W_MAX = 28,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W_MAX-1:0]        in_data,
  input  logic [1:0]                 in_mode,
  input  logic [1:0]                 in_wsel,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_ovf,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [OUT_W-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic             mem_ovf  [DEPTH];
  logic             mem_err  [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  logic [OUT_W-1:0] ext_value;
  logic             ext_ovf;
  logic             ext_err;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .OUT_W    (OUT_W),
    .IN_W_MAX (IN_W_MAX)
  ) u_core (
    .data  (in_data),
    .mode  (in_mode),
    .wsel  (in_wsel),
    .value (ext_value),
    .ovf   (ext_ovf),
    .err   (ext_err)
  );

  // in_ready depends only on registered occupancy: a full buffer refuses even during a pop.
  assign in_ready  = !rst && (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = mem_data[rptr];
  assign out_tag  = mem_tag[rptr];
  assign out_ovf  = mem_ovf[rptr];
  assign out_err  = mem_err[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
        mem_ovf[i]  <= 1'b0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wptr] <= ext_value;
        mem_tag[wptr]  <= in_tag;
        mem_ovf[wptr]  <= ext_ovf;
        mem_err[wptr]  <= ext_err;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
